tpu_cfg_bridge: RTL and testbench

- Parametrised successor to the fixed UART-to-MLP bridge.
- Passes weight-FIFO and activation controls from the UART controller to the MLP top, as before.
- Replaces the hardwired activation pipeline constants with a byte-writable shadow/active configuration bank; shadow values are committed only while the MLP is idle.
- Adds a start-deferral handshake and a done-triggered accumulator snapshot with valid/ack and overrun flagging.

---
 rtl/tpu_cfg_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_tpu_cfg_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_cfg_bridge.sv
// tpu_cfg_bridge: carries UART-controller commands to the MLP core, holds a
//   byte-writable shadow/active configuration bank for the activation
//   pipeline, defers MLP starts behind pending commits, and snapshots the
//   accumulator columns each time the MLP reaches its done state.
// Latency: command, state and cycle-count pass-through is combinational.
//   Shadow writes are visible 1 cycle later. A direct start pulse is 1 cycle
//   later. The active bank updates at the first edge where a commit is
//   pending and the MLP is idle.
// Backpressure: a commit issued while the MLP is busy waits with no time
//   limit, and any start is held back until that commit completes
//   (cfg_busy stays high meanwhile). The snapshot is not backpressured: a
//   new capture overwrites an unacknowledged one and sets res_overrun.
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   ctrl_* -> mlp_*             controller commands passed through to the MLP
//   cfg_wr_valid/addr/wdata     byte writes into the shadow bank
//   cfg_commit                  request a shadow->active copy
//   cfg_busy, cfg_err           pending status, sticky illegal-address flag
//   mlp_vpu_activation_type ... mlp_q_zero_point   active config registers
//   mlp_state_in/cycle_cnt_in/acc_in   MLP status in
//   mlp_state, mlp_cycle_cnt    status pass-through
//   res_acc/valid/ack/overrun   accumulator snapshot with valid/ack handshake
module tpu_cfg_bridge #(
  parameter int N_COL      = 2,
  parameter int ACC_W      = 32,
  parameter int STATE_W    = 4,
  parameter int IDLE_STATE = 0,
  parameter int DONE_STATE = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ctrl_wf_push_col0,
  input  logic                     ctrl_wf_push_col1,
  input  logic [7:0]               ctrl_wf_data_in,
  input  logic                     ctrl_wf_reset,
  input  logic                     ctrl_init_act_valid,
  input  logic [15:0]              ctrl_init_act_data,
  input  logic                     ctrl_weights_ready,
  input  logic                     ctrl_start_mlp,
  input  logic                     cfg_wr_valid,
  input  logic [3:0]               cfg_addr,
  input  logic [7:0]               cfg_wdata,
  input  logic                     cfg_commit,
  output logic                     cfg_busy,
  output logic                     cfg_err,
  output logic                     mlp_wf_push_col0,
  output logic                     mlp_wf_push_col1,
  output logic [7:0]               mlp_wf_data_in,
  output logic                     mlp_wf_reset,
  output logic                     mlp_init_act_valid,
  output logic [15:0]              mlp_init_act_data,
  output logic                     mlp_weights_ready,
  output logic                     mlp_start_mlp,
  output logic [2:0]               mlp_vpu_activation_type,
  output logic [15:0]              mlp_norm_gain,
  output logic [31:0]              mlp_norm_bias,
  output logic [4:0]               mlp_norm_shift,
  output logic [15:0]              mlp_q_inv_scale,
  output logic [7:0]               mlp_q_zero_point,
  input  logic [STATE_W-1:0]       mlp_state_in,
  input  logic [4:0]               mlp_cycle_cnt_in,
  input  logic [N_COL*ACC_W-1:0]   mlp_acc_in,
  output logic [STATE_W-1:0]       mlp_state,
  output logic [4:0]               mlp_cycle_cnt,
  output logic [N_COL*ACC_W-1:0]   res_acc,
  output logic                     res_valid,
  input  logic                     res_ack,
  output logic                     res_overrun
);

  localparam logic [STATE_W-1:0] IDLE_S = STATE_W'(IDLE_STATE);
  localparam logic [STATE_W-1:0] DONE_S = STATE_W'(DONE_STATE);

  // Power-on defaults: ReLU, unity gain/scale in Q8, shift of 8.
  localparam logic [2:0]  ACT_RST   = 3'b001;
  localparam logic [15:0] GAIN_RST  = 16'd256;
  localparam logic [31:0] BIAS_RST  = 32'd0;
  localparam logic [4:0]  SHIFT_RST = 5'd8;
  localparam logic [15:0] SCALE_RST = 16'd256;
  localparam logic [7:0]  ZP_RST    = 8'd0;

  // Command and status pass-through.
  assign mlp_wf_push_col0   = ctrl_wf_push_col0;
  assign mlp_wf_push_col1   = ctrl_wf_push_col1;
  assign mlp_wf_data_in     = ctrl_wf_data_in;
  assign mlp_wf_reset       = ctrl_wf_reset;
  assign mlp_init_act_valid = ctrl_init_act_valid;
  assign mlp_init_act_data  = ctrl_init_act_data;
  assign mlp_weights_ready  = ctrl_weights_ready;
  assign mlp_state          = mlp_state_in;
  assign mlp_cycle_cnt      = mlp_cycle_cnt_in;

  // Shadow bank.
  logic [2:0]  sh_act;
  logic [15:0] sh_gain;
  logic [31:0] sh_bias;
  logic [4:0]  sh_shift;
  logic [15:0] sh_scale;
  logic [7:0]  sh_zp;

  logic commit_pend;
  logic start_pend;
  logic [STATE_W-1:0] prev_state;

  logic do_commit;
  logic fire_start;
  logic start_pend_nxt;
  logic capture;

  // The copy happens only while the MLP reports idle.
  assign do_commit = commit_pend && (mlp_state_in == IDLE_S);

  // A start (fresh or held) is launched when no commit is outstanding after
  // this edge. A fresh cfg_commit keeps the start waiting for that commit,
  // so the MLP always starts with the configuration that was asked for.
  always_comb begin
    fire_start     = 1'b0;
    start_pend_nxt = start_pend;
    if ((ctrl_start_mlp || start_pend) && !cfg_commit &&
        (!commit_pend || do_commit)) begin
      fire_start     = 1'b1;
      start_pend_nxt = 1'b0;
    end else if (ctrl_start_mlp) begin
      start_pend_nxt = 1'b1;
    end
  end

  assign cfg_busy = commit_pend | start_pend;

  // Shadow byte writes, little-endian fields; illegal addresses flag an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_act   <= ACT_RST;
      sh_gain  <= GAIN_RST;
      sh_bias  <= BIAS_RST;
      sh_shift <= SHIFT_RST;
      sh_scale <= SCALE_RST;
      sh_zp    <= ZP_RST;
      cfg_err  <= 1'b0;
    end else if (cfg_wr_valid) begin
      case (cfg_addr)
        4'd0:    sh_act          <= cfg_wdata[2:0];
        4'd1:    sh_gain[7:0]    <= cfg_wdata;
        4'd2:    sh_gain[15:8]   <= cfg_wdata;
        4'd3:    sh_bias[7:0]    <= cfg_wdata;
        4'd4:    sh_bias[15:8]   <= cfg_wdata;
        4'd5:    sh_bias[23:16]  <= cfg_wdata;
        4'd6:    sh_bias[31:24]  <= cfg_wdata;
        4'd7:    sh_shift        <= cfg_wdata[4:0];
        4'd8:    sh_scale[7:0]   <= cfg_wdata;
        4'd9:    sh_scale[15:8]  <= cfg_wdata;
        4'd10:   sh_zp           <= cfg_wdata;
        default: cfg_err         <= 1'b1;
      endcase
    end
  end

  // Active bank: copies the shadow as it stood before this edge, so a write
  // landing on the commit edge stays in the shadow for the next commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mlp_vpu_activation_type <= ACT_RST;
      mlp_norm_gain           <= GAIN_RST;
      mlp_norm_bias           <= BIAS_RST;
      mlp_norm_shift          <= SHIFT_RST;
      mlp_q_inv_scale         <= SCALE_RST;
      mlp_q_zero_point        <= ZP_RST;
    end else if (do_commit) begin
      mlp_vpu_activation_type <= sh_act;
      mlp_norm_gain           <= sh_gain;
      mlp_norm_bias           <= sh_bias;
      mlp_norm_shift          <= sh_shift;
      mlp_q_inv_scale         <= sh_scale;
      mlp_q_zero_point        <= sh_zp;
    end
  end

  // Commit / start sequencing. A new cfg_commit on the copy edge re-arms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_pend   <= 1'b0;
      start_pend    <= 1'b0;
      mlp_start_mlp <= 1'b0;
    end else begin
      commit_pend   <= cfg_commit | (commit_pend & ~do_commit);
      start_pend    <= start_pend_nxt;
      mlp_start_mlp <= fire_start;
    end
  end

  // Snapshot on entry into the done state only.
  assign capture = (mlp_state_in == DONE_S) && (prev_state != DONE_S);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state  <= IDLE_S;
      res_acc     <= '0;
      res_valid   <= 1'b0;
      res_overrun <= 1'b0;
    end else begin
      prev_state <= mlp_state_in;
      if (capture) begin
        res_acc   <= mlp_acc_in;
        res_valid <= 1'b1;
        // An ack in the same cycle consumes the old snapshot, so no loss.
        if (res_valid && !res_ack) begin
          res_overrun <= 1'b1;
        end
      end else if (res_ack) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tpu_cfg_bridge.sv
// Bench for tpu_cfg_bridge: directed stimulus pushes expected values into
// queues; a negedge monitor pops and compares them, and checks every start
// pulse against the cycle at which one is expected.
module tb_tpu_cfg_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ctrl_wf_push_col0 = 0, ctrl_wf_push_col1 = 0, ctrl_wf_reset = 0;
  logic [7:0]  ctrl_wf_data_in = 0;
  logic        ctrl_init_act_valid = 0, ctrl_weights_ready = 0;
  logic [15:0] ctrl_init_act_data = 0;
  logic        ctrl_start_mlp = 0;
  logic        cfg_wr_valid = 0, cfg_commit = 0;
  logic [3:0]  cfg_addr = 0;
  logic [7:0]  cfg_wdata = 0;
  logic        cfg_busy, cfg_err;
  logic        mlp_wf_push_col0, mlp_wf_push_col1, mlp_wf_reset;
  logic [7:0]  mlp_wf_data_in;
  logic        mlp_init_act_valid, mlp_weights_ready, mlp_start_mlp;
  logic [15:0] mlp_init_act_data;
  logic [2:0]  mlp_vpu_activation_type;
  logic [15:0] mlp_norm_gain, mlp_q_inv_scale;
  logic [31:0] mlp_norm_bias;
  logic [4:0]  mlp_norm_shift;
  logic [7:0]  mlp_q_zero_point;
  logic [3:0]  mlp_state_in = 0, mlp_state;
  logic [4:0]  mlp_cycle_cnt_in = 0, mlp_cycle_cnt;
  logic [63:0] mlp_acc_in = 0, res_acc;
  logic        res_valid, res_ack = 0, res_overrun;

  tpu_cfg_bridge dut (
    .clk(clk), .rst(rst),
    .ctrl_wf_push_col0(ctrl_wf_push_col0), .ctrl_wf_push_col1(ctrl_wf_push_col1),
    .ctrl_wf_data_in(ctrl_wf_data_in), .ctrl_wf_reset(ctrl_wf_reset),
    .ctrl_init_act_valid(ctrl_init_act_valid), .ctrl_init_act_data(ctrl_init_act_data),
    .ctrl_weights_ready(ctrl_weights_ready), .ctrl_start_mlp(ctrl_start_mlp),
    .cfg_wr_valid(cfg_wr_valid), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .mlp_wf_push_col0(mlp_wf_push_col0), .mlp_wf_push_col1(mlp_wf_push_col1),
    .mlp_wf_data_in(mlp_wf_data_in), .mlp_wf_reset(mlp_wf_reset),
    .mlp_init_act_valid(mlp_init_act_valid), .mlp_init_act_data(mlp_init_act_data),
    .mlp_weights_ready(mlp_weights_ready), .mlp_start_mlp(mlp_start_mlp),
    .mlp_vpu_activation_type(mlp_vpu_activation_type), .mlp_norm_gain(mlp_norm_gain),
    .mlp_norm_bias(mlp_norm_bias), .mlp_norm_shift(mlp_norm_shift),
    .mlp_q_inv_scale(mlp_q_inv_scale), .mlp_q_zero_point(mlp_q_zero_point),
    .mlp_state_in(mlp_state_in), .mlp_cycle_cnt_in(mlp_cycle_cnt_in),
    .mlp_acc_in(mlp_acc_in), .mlp_state(mlp_state), .mlp_cycle_cnt(mlp_cycle_cnt),
    .res_acc(res_acc), .res_valid(res_valid), .res_ack(res_ack),
    .res_overrun(res_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_ACT = 0, S_GAIN = 1, S_BIAS = 2, S_SHIFT = 3, S_SCALE = 4,
                 S_ZP = 5, S_VALID = 6, S_BUSY = 7, S_ERR = 8, S_OVR = 9,
                 S_ACC = 10, S_WFD = 11, S_STATE = 12;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t chk_q[$];
  int   start_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [63:0] get_sig(input int sel);
    case (sel)
      S_ACT:   return 64'(mlp_vpu_activation_type);
      S_GAIN:  return 64'(mlp_norm_gain);
      S_BIAS:  return 64'(mlp_norm_bias);
      S_SHIFT: return 64'(mlp_norm_shift);
      S_SCALE: return 64'(mlp_q_inv_scale);
      S_ZP:    return 64'(mlp_q_zero_point);
      S_VALID: return 64'(res_valid);
      S_BUSY:  return 64'(cfg_busy);
      S_ERR:   return 64'(cfg_err);
      S_OVR:   return 64'(res_overrun);
      S_ACC:   return res_acc;
      S_WFD:   return 64'(mlp_wf_data_in);
      S_STATE: return 64'(mlp_state);
      default: return 64'hDEAD;
    endcase
  endfunction

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (mlp_start_mlp) begin
      n_chk++;
      if (start_q.size() == 0) begin
        $display("FAIL start_unexpected: pulse at cycle %0d, none required", cyc);
      end else begin
        int e;
        e = start_q.pop_front();
        if (e == cyc) n_pass++;
        else $display("FAIL start_cycle: pulse at cycle %0d, required %0d", cyc, e);
      end
    end
    while (chk_q.size() > 0) begin
      chk_t c;
      logic [63:0] a;
      c = chk_q.pop_front();
      a = get_sig(c.sel);
      n_chk++;
      if (a === c.exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", c.name, a, c.exp);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_v(input string name, input int sel, input logic [63:0] exp);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cfg_wr_valid = 1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr_valid = 0;
  endtask

  task automatic do_commit();
    cfg_commit = 1;
    step();
    cfg_commit = 0;
  endtask

  task automatic expect_defaults(input string tag);
    expect_v({tag, "_act"},   S_ACT,   64'd1);
    expect_v({tag, "_gain"},  S_GAIN,  64'd256);
    expect_v({tag, "_bias"},  S_BIAS,  64'd0);
    expect_v({tag, "_shift"}, S_SHIFT, 64'd8);
    expect_v({tag, "_scale"}, S_SCALE, 64'd256);
    expect_v({tag, "_zp"},    S_ZP,    64'd0);
    expect_v({tag, "_valid"}, S_VALID, 64'd0);
    expect_v({tag, "_busy"},  S_BUSY,  64'd0);
    expect_v({tag, "_err"},   S_ERR,   64'd0);
    expect_v({tag, "_ovr"},   S_OVR,   64'd0);
    expect_v({tag, "_acc"},   S_ACC,   64'd0);
  endtask

  initial begin
    #2 rst = 1;
    step(3);
    rst = 0;
    step();
    expect_defaults("reset");

    // Pass-through.
    ctrl_wf_data_in = 8'hA5; mlp_state_in = 4'd5;
    expect_v("pass_wf_data", S_WFD, 64'hA5);
    expect_v("pass_state",   S_STATE, 64'd5);
    step();
    mlp_state_in = 4'd0;
    step();

    // Shadow writes, then commit while idle.
    wr(0, 8'h02); wr(1, 8'h00); wr(2, 8'h02);
    wr(3, 8'h78); wr(4, 8'h56); wr(5, 8'h34); wr(6, 8'h12);
    wr(7, 8'hE3); wr(8, 8'h34); wr(9, 8'h12);
    expect_v("precommit_act",  S_ACT,  64'd1);
    expect_v("precommit_gain", S_GAIN, 64'd256);
    do_commit();
    expect_v("commit_pend_busy", S_BUSY, 64'd1);
    expect_v("commit_pend_act",  S_ACT,  64'd1);
    step();
    expect_v("commit_act",   S_ACT,   64'd2);
    expect_v("commit_gain",  S_GAIN,  64'd512);
    expect_v("commit_bias",  S_BIAS,  64'h12345678);
    expect_v("commit_shift", S_SHIFT, 64'd3);
    expect_v("commit_scale", S_SCALE, 64'h1234);
    expect_v("commit_busy",  S_BUSY,  64'd0);

    // Write landing on the copy edge is held for the next commit.
    do_commit();
    wr(10, 8'h7F);
    expect_v("edge_write_zp", S_ZP, 64'd0);
    do_commit();
    step();
    expect_v("late_commit_zp", S_ZP, 64'h7F);

    // Commit while busy; starts defer and collapse into one.
    wr(0, 8'h03);
    mlp_state_in = 4'd3;
    do_commit();
    ctrl_start_mlp = 1; step();
    ctrl_start_mlp = 0; step();
    ctrl_start_mlp = 1; step();
    ctrl_start_mlp = 0;
    step(3);
    expect_v("busy_wait_busy", S_BUSY, 64'd1);
    expect_v("busy_wait_act",  S_ACT,  64'd2);
    mlp_state_in = 4'd0;
    start_q.push_back(cyc + 1);
    step();
    expect_v("deferred_act",  S_ACT,  64'd3);
    expect_v("deferred_busy", S_BUSY, 64'd0);
    step(3);

    // Direct start: one-cycle registered pulse.
    start_q.push_back(cyc + 1);
    ctrl_start_mlp = 1; step();
    ctrl_start_mlp = 0;
    step(2);

    // Start together with commit while idle: pulse follows the commit edge.
    start_q.push_back(cyc + 2);
    cfg_commit = 1; ctrl_start_mlp = 1; step();
    cfg_commit = 0; ctrl_start_mlp = 0;
    step(3);

    // Illegal address.
    wr(12, 8'hFF);
    expect_v("illegal_err", S_ERR, 64'd1);
    do_commit();
    step();
    expect_v("illegal_act",  S_ACT,  64'd3);
    expect_v("illegal_gain", S_GAIN, 64'd512);
    expect_v("illegal_zp",   S_ZP,   64'h7F);
    step(4);
    expect_v("illegal_err_sticky", S_ERR, 64'd1);

    // Capture: entry to done snapshots the accumulators.
    mlp_acc_in = {32'd100, 32'hFFFF_FFF9};
    mlp_state_in = 4'd5; step();
    mlp_state_in = 4'd6; step();
    expect_v("cap1_acc",   S_ACC,   {32'd100, 32'hFFFF_FFF9});
    expect_v("cap1_valid", S_VALID, 64'd1);
    expect_v("cap1_ovr",   S_OVR,   64'd0);
    mlp_acc_in = 64'h1111_2222_3333_4444;
    step(2);
    expect_v("hold_done_acc", S_ACC, {32'd100, 32'hFFFF_FFF9});
    expect_v("hold_done_ovr", S_OVR, 64'd0);
    mlp_state_in = 4'd0; step();
    mlp_acc_in = {32'd5, 32'd6};
    mlp_state_in = 4'd6; res_ack = 1; step();
    res_ack = 0;
    expect_v("ack_cap_acc",   S_ACC,   {32'd5, 32'd6});
    expect_v("ack_cap_valid", S_VALID, 64'd1);
    expect_v("ack_cap_ovr",   S_OVR,   64'd0);
    mlp_state_in = 4'd0; res_ack = 1; step();
    res_ack = 0;
    expect_v("ack_only_valid", S_VALID, 64'd0);
    mlp_acc_in = {32'd7, 32'd8};
    mlp_state_in = 4'd6; step();
    mlp_state_in = 4'd0; step();
    expect_v("cap3_valid", S_VALID, 64'd1);
    expect_v("cap3_ovr",   S_OVR,   64'd0);
    mlp_acc_in = {32'd9, 32'd10};
    mlp_state_in = 4'd6; step();
    expect_v("overrun_acc", S_ACC, {32'd9, 32'd10});
    expect_v("overrun_ovr", S_OVR, 64'd1);
    mlp_state_in = 4'd0; step();

    // Reset during pending commit and start: no pulse, defaults return.
    mlp_state_in = 4'd3;
    wr(1, 8'h11);
    do_commit();
    ctrl_start_mlp = 1; step();
    ctrl_start_mlp = 0;
    expect_v("pre_rst_busy", S_BUSY, 64'd1);
    step();
    #2 rst = 1;
    step();
    rst = 0;
    mlp_state_in = 4'd0;
    step();
    expect_defaults("midrst");
    step(4);

    // Every required start pulse must have been seen.
    @(negedge clk);
    #1;
    n_chk++;
    if (start_q.size() == 0) n_pass++;
    else $display("FAIL start_missing: %0d pulses outstanding, required 0", start_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
